// File: rtl/dac_frame_scheduler.sv
// Paced buffer between ADC_SPI_In and DAC_SPI_Out: queues ADC samples and emits one DAC frame per interval tick.
// Build option: define RAMP_TEST_EN to send a ramp test pattern instead of FIFO samples.
module dac_frame_scheduler #(
    parameter int unsigned SEND_INTERVAL   = 3624,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2,
    parameter logic [7:0]  CHANNEL_CMD     = 8'b00110001,
    parameter logic [15:0] RAMP_STEP       = 16'd64
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [15:0]              adc_data,
    input  logic                     adc_data_received,
    input  logic                     dac_busy,
    output logic [23:0]              dac_data,
    output logic                     send,
    output logic [FIFO_DEPTH_LOG2:0] fifo_level,
    output logic                     overflow,
    output logic [15:0]              underrun_count
);
    localparam int DATA_W  = 16;
    localparam int FRAME_W = 24;
    localparam int ADDR_W  = FIFO_DEPTH_LOG2;
    localparam int PTR_W   = FIFO_DEPTH_LOG2 + 1;
    localparam int CNT_W   = $clog2(SEND_INTERVAL);

    localparam logic [CNT_W-1:0] CNT_LAST        = CNT_W'(SEND_INTERVAL - 1);
    localparam logic [PTR_W-1:0] FIFO_FULL_LEVEL = PTR_W'(1 << FIFO_DEPTH_LOG2);
    localparam logic [3:0]       BUSY_WAIT_LAST  = 4'd14;

    if (SEND_INTERVAL < 8) begin : g_bad_interval
        $error("SEND_INTERVAL must be at least 8");
    end
    if (RAMP_STEP == 16'd0) begin : g_flat_ramp
        $warning("RAMP_STEP is zero: the ramp pattern will be constant");
    end

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    interval_cnt;
    logic                tick;
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic                fifo_empty;
    logic                fifo_full;
    logic                push;
    logic                pop;
    logic                overflow_q;
    logic [15:0]         underrun_q;
    logic                underrun_en;
    logic [3:0]          busy_wait_cnt;
    logic [DATA_W-1:0]   load_sample;
    logic [FRAME_W-1:0]  frame_p2;
    logic                vld_p2;

    // Interval counter, free-running regardless of FSM state
    always_ff @(posedge clock) begin
        if (reset) begin
            interval_cnt <= '0;
        end else if (tick) begin
            interval_cnt <= '0;
        end else begin
            interval_cnt <= interval_cnt + CNT_W'(1);
        end
    end

    assign tick = (interval_cnt == CNT_LAST);

    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (fifo_level == FIFO_FULL_LEVEL);
    // A push into a full FIFO is accepted when the same cycle pops
    assign push       = adc_data_received && (!fifo_full || pop);

`ifdef RAMP_TEST_EN
    logic [DATA_W-1:0] ramp_q;

    assign pop         = 1'b0;
    assign load_sample = ramp_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            ramp_q <= 16'd1;
        end else if (state_q == LOAD) begin
            ramp_q <= ramp_q + RAMP_STEP;
        end
    end
`else
    logic [DATA_W-1:0] fifo_mem [1 << FIFO_DEPTH_LOG2];

    assign pop         = (state_q == LOAD) && !fifo_empty;
    assign load_sample = fifo_mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clock) begin
        if (push) begin
            fifo_mem[wr_ptr[ADDR_W-1:0]] <= adc_data;
        end
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (adc_data_received && fifo_full && !pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        underrun_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick) begin
`ifdef RAMP_TEST_EN
                    state_d = LOAD;
`else
                    if (!fifo_empty) begin
                        state_d = LOAD;
                    end else begin
                        underrun_en = 1'b1;
                    end
`endif
                end
            end
            LOAD:      state_d = SEND;
            SEND:      state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (dac_busy) begin
                    state_d = WAIT_DONE;
                end else if (busy_wait_cnt == BUSY_WAIT_LAST) begin
                    state_d = IDLE;
                end
            end
            WAIT_DONE: begin
                if (!dac_busy) begin
                    state_d = IDLE;
                end
            end
            default:   state_d = IDLE;
        endcase
    end

    // Output stage: frame latched in LOAD, send pulse follows in the SEND cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_p2      <= '0;
            vld_p2        <= 1'b0;
            underrun_q    <= '0;
            busy_wait_cnt <= '0;
        end else begin
            vld_p2 <= (state_q == LOAD);
            if (state_q == LOAD) begin
                frame_p2 <= {CHANNEL_CMD, load_sample};
            end
            if (underrun_en) begin
                underrun_q <= sat_inc16(underrun_q);
            end
            if (state_q == WAIT_BUSY) begin
                busy_wait_cnt <= busy_wait_cnt + 4'd1;
            end else begin
                busy_wait_cnt <= '0;
            end
        end
    end

    assign dac_data       = frame_p2;
    assign send           = vld_p2;
    assign overflow       = overflow_q;
    assign underrun_count = underrun_q;

endmodule

// File: tb/tb_dac_frame_scheduler.sv
// Directed bench for dac_frame_scheduler with a short send interval and a behavioural DAC busy model.
module tb_dac_frame_scheduler;
    localparam int SI = 18;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] adc_data = 16'h0;
    logic        adc_data_received = 1'b0;
    logic        dac_busy;
    logic [23:0] dac_data;
    logic        send;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [15:0] underrun_count;

    int checks = 0;
    int passed = 0;
    int ph;
    int busy_mode = 1;
    int busy_left = 0;
    logic [23:0] frames [$];

    dac_frame_scheduler #(.SEND_INTERVAL(SI)) dut (
        .clock             (clock),
        .reset             (reset),
        .adc_data          (adc_data),
        .adc_data_received (adc_data_received),
        .dac_busy          (dac_busy),
        .dac_data          (dac_data),
        .send              (send),
        .fifo_level        (fifo_level),
        .overflow          (overflow),
        .underrun_count    (underrun_count)
    );

    always #5 clock = ~clock;

    // Tick phase: the tick cycle is the one where ph == SI-1
    always @(posedge clock) begin
        if (reset) ph <= 0;
        else       ph <= (ph == SI - 1) ? 0 : ph + 1;
    end

    // DAC model: busy for 4 (mode 1) or 20 (mode 2) cycles after send, never in mode 0
    always @(negedge clock) begin
        if (reset) begin
            busy_left = 0;
            dac_busy  = 1'b0;
        end else begin
            if (send === 1'b1) begin
                frames.push_back(dac_data);
                busy_left = (busy_mode == 1) ? 4 : (busy_mode == 2) ? 20 : 0;
            end
            dac_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "bench timeout");
    end

    task automatic reset_dut(input int mode);
        busy_mode = mode;
        reset = 1'b1;
        adc_data_received = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic push(input logic [15:0] d);
        adc_data = d;
        adc_data_received = 1'b1;
        @(negedge clock);
        adc_data_received = 1'b0;
    endtask

    task automatic wait_tick();
        bit hit = 1'b0;
        for (int i = 0; i < SI + 1 && !hit; i++) begin
            @(negedge clock);
            if (ph == SI - 1) hit = 1'b1;
        end
    endtask

    task automatic wait_send(input string name, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clock);
            if (send === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) $display("FAIL %s got no send want send within %0d cycles", name, limit);
        else passed++;
    endtask

    task automatic test_reset();
        reset_dut(1);
        @(negedge clock);
        checks++; if (send !== 1'b0) $display("FAIL reset_send got %0h want 0", send); else passed++;
        checks++; if (dac_data !== 24'h0) $display("FAIL reset_dac_data got %h want 000000", dac_data); else passed++;
        checks++; if (fifo_level !== 3'd0) $display("FAIL reset_level got %0d want 0", fifo_level); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0h want 0", overflow); else passed++;
        checks++; if (underrun_count !== 16'h0) $display("FAIL reset_underrun got %h want 0000", underrun_count); else passed++;
    endtask

`ifdef RAMP_TEST_EN
    task automatic test_ramp_reset_midop();
        reset_dut(2);
        wait_send("ramp_first", 3 * SI);
        checks++; if (dac_data !== 24'h310001) $display("FAIL ramp_first got %h want 310001", dac_data); else passed++;
        repeat (6) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (send !== 1'b0) $display("FAIL ramp_rst_send got %0h want 0", send); else passed++;
        checks++; if (dac_data !== 24'h0) $display("FAIL ramp_rst_data got %h want 000000", dac_data); else passed++;
        checks++; if (fifo_level !== 3'd0) $display("FAIL ramp_rst_level got %0d want 0", fifo_level); else passed++;
        checks++; if (underrun_count !== 16'h0) $display("FAIL ramp_rst_underrun got %h want 0000", underrun_count); else passed++;
        reset = 1'b0;
        busy_mode = 1;
        wait_send("ramp_after_1", 3 * SI);
        checks++; if (dac_data !== 24'h310001) $display("FAIL ramp_after_1 got %h want 310001", dac_data); else passed++;
        wait_send("ramp_after_2", 3 * SI);
        checks++; if (dac_data !== 24'h310041) $display("FAIL ramp_after_2 got %h want 310041", dac_data); else passed++;
    endtask

    task automatic test_ramp_fifo();
        reset_dut(1);
        for (int i = 1; i <= 5; i++) push(16'(i));
        checks++; if (overflow !== 1'b1) $display("FAIL ramp_overflow got %0h want 1", overflow); else passed++;
        wait_send("ramp_fifo_send", 3 * SI);
        repeat (SI + 4) @(negedge clock);
        checks++; if (fifo_level !== 3'd4) $display("FAIL ramp_no_pop got %0d want 4", fifo_level); else passed++;
        checks++; if (underrun_count !== 16'h0) $display("FAIL ramp_underrun got %h want 0000", underrun_count); else passed++;
    endtask
`else
    task automatic test_single_sample();
        int base;
        reset_dut(2);
        base = frames.size();
        push(16'h1234);
        checks++; if (fifo_level !== 3'd1) $display("FAIL single_level_push got %0d want 1", fifo_level); else passed++;
        wait_tick();
        checks++; if (send !== 1'b0) $display("FAIL single_send_T got %0h want 0", send); else passed++;
        @(negedge clock);
        checks++; if (send !== 1'b0) $display("FAIL single_send_T1 got %0h want 0", send); else passed++;
        @(negedge clock);
        checks++; if (send !== 1'b1) $display("FAIL single_send_T2 got %0h want 1", send); else passed++;
        checks++; if (dac_data !== 24'h311234) $display("FAIL single_frame got %h want 311234", dac_data); else passed++;
        checks++; if (fifo_level !== 3'd0) $display("FAIL single_level_pop got %0d want 0", fifo_level); else passed++;
        repeat (28) @(negedge clock);
        checks++; if (frames.size() - base !== 1) $display("FAIL busy_tick_ignored got %0d sends want 1", frames.size() - base); else passed++;
        checks++; if (underrun_count !== 16'h0) $display("FAIL busy_tick_not_counted got %h want 0000", underrun_count); else passed++;
        checks++; if (dac_data !== 24'h311234) $display("FAIL single_hold got %h want 311234", dac_data); else passed++;
    endtask

    task automatic test_overflow();
        int base;
        reset_dut(1);
        base = frames.size();
        for (int i = 1; i <= 4; i++) push(16'(i));
        checks++; if (overflow !== 1'b0) $display("FAIL ovf_before got %0h want 0", overflow); else passed++;
        push(16'h0005);
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_after got %0h want 1", overflow); else passed++;
        checks++; if (fifo_level !== 3'd4) $display("FAIL ovf_level got %0d want 4", fifo_level); else passed++;
        for (int k = 0; k < 4; k++) wait_send("ovf_frame", 2 * SI);
        repeat (SI + 4) @(negedge clock);
        checks++; if (frames.size() - base !== 4) $display("FAIL ovf_count got %0d want 4", frames.size() - base); else passed++;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (frames[base + k] !== (24'h310000 | 24'(k + 1)))
                $display("FAIL ovf_frame%0d got %h want %h", k, frames[base + k], 24'h310000 | 24'(k + 1));
            else passed++;
        end
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky got %0h want 1", overflow); else passed++;
        checks++; if (underrun_count !== 16'd1) $display("FAIL ovf_underrun got %h want 0001", underrun_count); else passed++;
    endtask

    task automatic test_underrun();
        int base;
        reset_dut(1);
        base = frames.size();
        wait_tick();
        @(negedge clock);
        checks++; if (underrun_count !== 16'd1) $display("FAIL underrun_T1 got %h want 0001", underrun_count); else passed++;
        @(negedge clock);
        checks++; if (send !== 1'b0) $display("FAIL underrun_send got %0h want 0", send); else passed++;
        wait_tick();
        wait_tick();
        @(negedge clock);
        checks++; if (underrun_count !== 16'd3) $display("FAIL underrun_3 got %h want 0003", underrun_count); else passed++;
        checks++; if (dac_data !== 24'h0) $display("FAIL underrun_data got %h want 000000", dac_data); else passed++;
        checks++; if (frames.size() !== base) $display("FAIL underrun_sends got %0d want 0", frames.size() - base); else passed++;
        force dut.underrun_q = 16'hFFFF;
        @(negedge clock);
        release dut.underrun_q;
        wait_tick();
        @(negedge clock);
        checks++; if (underrun_count !== 16'hFFFF) $display("FAIL underrun_sat got %h want ffff", underrun_count); else passed++;
    endtask

    task automatic test_simultaneous();
        int base;
        reset_dut(1);
        base = frames.size();
        push(16'h0011); push(16'h0022); push(16'h0033); push(16'h0044);
        checks++; if (fifo_level !== 3'd4) $display("FAIL simul_full got %0d want 4", fifo_level); else passed++;
        wait_tick();
        @(negedge clock);
        push(16'hAAAA);
        checks++; if (fifo_level !== 3'd4) $display("FAIL simul_level got %0d want 4", fifo_level); else passed++;
        checks++; if (dac_data !== 24'h310011) $display("FAIL simul_frame0 got %h want 310011", dac_data); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL simul_overflow got %0h want 0", overflow); else passed++;
        for (int k = 0; k < 4; k++) wait_send("simul_frame", 2 * SI);
        @(negedge clock);
        checks++; if (frames[base + 3] !== 24'h310044) $display("FAIL simul_frame3 got %h want 310044", frames[base + 3]); else passed++;
        checks++; if (frames[base + 4] !== 24'h31AAAA) $display("FAIL simul_frame4 got %h want 31aaaa", frames[base + 4]); else passed++;
        checks++; if (fifo_level !== 3'd0) $display("FAIL simul_drained got %0d want 0", fifo_level); else passed++;
        checks++; if (overflow !== 1'b0) $display("FAIL simul_overflow_end got %0h want 0", overflow); else passed++;
    endtask

    task automatic test_busy_timeout();
        reset_dut(0);
        push(16'h0101);
        push(16'h0202);
        wait_tick();
        repeat (2) @(negedge clock);
        checks++; if (send !== 1'b1) $display("FAIL tmo_send1 got %0h want 1", send); else passed++;
        checks++; if (dac_data !== 24'h310101) $display("FAIL tmo_frame1 got %h want 310101", dac_data); else passed++;
        repeat (17) @(negedge clock);
        checks++; if (send !== 1'b0) $display("FAIL tmo_quiet got %0h want 0", send); else passed++;
        @(negedge clock);
        checks++; if (send !== 1'b1) $display("FAIL tmo_send2 got %0h want 1", send); else passed++;
        checks++; if (dac_data !== 24'h310202) $display("FAIL tmo_frame2 got %h want 310202", dac_data); else passed++;
    endtask

    task automatic test_reset_midop();
        reset_dut(2);
        push(16'h5555);
        push(16'h6666);
        wait_send("midop_send", 3 * SI);
        repeat (6) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (send !== 1'b0) $display("FAIL midop_send got %0h want 0", send); else passed++;
        checks++; if (dac_data !== 24'h0) $display("FAIL midop_data got %h want 000000", dac_data); else passed++;
        checks++; if (fifo_level !== 3'd0) $display("FAIL midop_level got %0d want 0", fifo_level); else passed++;
        reset = 1'b0;
        busy_mode = 1;
        wait_tick();
        @(negedge clock);
        checks++; if (underrun_count !== 16'd1) $display("FAIL midop_underrun got %h want 0001", underrun_count); else passed++;
        @(negedge clock);
        checks++; if (send !== 1'b0) $display("FAIL midop_no_resend got %0h want 0", send); else passed++;
    endtask
`endif

    initial begin
        test_reset();
`ifdef RAMP_TEST_EN
        test_ramp_reset_midop();
        test_ramp_fifo();
`else
        test_single_sample();
        test_overflow();
        test_underrun();
        test_simultaneous();
        test_busy_timeout();
        test_reset_midop();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
